// File: rtl/cpsr_flag_ctrl_if.sv
// Instruction, ALU and CPSR signal bundle for cpsr_flag_ctrl.
// master = instruction source / ALU / CPSR side, slave = the sequencer.
interface cpsr_flag_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_class;
  logic [2:0] cond;
  logic       alu_start;
  logic       alu_done;
  logic       alu_n;
  logic       alu_v;
  logic       alu_z;
  logic       negative_flag_and;
  logic       overflow_and;
  logic       zero_flag_and;
  logic [2:0] svz;
  logic       branch_valid;
  logic       branch_taken;
  logic       alu_err;

  modport master (
    output instr_valid, instr_class, cond, alu_done, alu_n, alu_v, alu_z, svz,
    input  instr_ready, alu_start, negative_flag_and, overflow_and, zero_flag_and,
           branch_valid, branch_taken, alu_err
  );

  modport slave (
    input  instr_valid, instr_class, cond, alu_done, alu_n, alu_v, alu_z, svz,
    output instr_ready, alu_start, negative_flag_and, overflow_and, zero_flag_and,
           branch_valid, branch_taken, alu_err
  );
endinterface

// File: rtl/cpsr_flag_ctrl.sv
// CPSR flag sequencer: runs ALU ops, commits S/V/Z, evaluates branches with interlock.
// Optional macro CPSR_FLAG_FWD_EN: branches use the held flags instead of waiting for CPSR.
module cpsr_flag_ctrl #(
  parameter int ALU_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cpsr_flag_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    EXEC    = 3'd2,
    BR_WAIT = 3'd3,
    BR_EVAL = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [TO_W-1:0] cnt_reg;
  logic [1:0]      cls_reg;
  logic [2:0]      cond_reg;
  logic [2:0]      flags_reg;
  logic            pending_reg;
  logic            err_reg;
  logic            transfer;
  logic            timeout_hit;
  logic            commit;
  logic [2:0]      eval_flags;

  assign transfer    = bus.instr_valid && (state_reg == IDLE);
  // The counter holds the number of completed EXEC cycles, so this is the last one allowed.
  assign timeout_hit = (cnt_reg == TO_W'(ALU_TIMEOUT - 1));
  assign commit      = (state_reg == EXEC) && bus.alu_done && (cls_reg == 2'b00);

  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
    logic s, v, z;
    {s, v, z} = f;
    case (c)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = z;
      3'b010:  cond_met = ~z;
      3'b011:  cond_met = s;
      3'b100:  cond_met = ~s;
      3'b101:  cond_met = v;
      3'b110:  cond_met = ~v;
      default: cond_met = ~z & (s == v);
    endcase
  endfunction

`ifdef CPSR_FLAG_FWD_EN
  logic fwd_sel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fwd_sel_reg <= 1'b0;
    else if (transfer)
      fwd_sel_reg <= pending_reg;
  end

  assign eval_flags = fwd_sel_reg ? flags_reg : bus.svz;
`else
  assign eval_flags = bus.svz;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    bus.instr_ready  = 1'b0;
    bus.alu_start    = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_taken = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.instr_ready = rst_n;
        if (transfer) begin
          case (bus.instr_class)
            2'b00, 2'b01: state_next = START;
`ifdef CPSR_FLAG_FWD_EN
            2'b10:        state_next = BR_EVAL;
`else
            2'b10:        state_next = pending_reg ? BR_WAIT : BR_EVAL;
`endif
            default:      state_next = IDLE;
          endcase
        end
      end
      START: begin
        bus.alu_start = 1'b1;
        state_next    = EXEC;
      end
      EXEC: begin
        if (bus.alu_done || timeout_hit)
          state_next = IDLE;
      end
      BR_WAIT: state_next = BR_EVAL;
      BR_EVAL: begin
        bus.branch_valid = 1'b1;
        bus.branch_taken = cond_met(cond_reg, eval_flags);
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      cls_reg     <= 2'b00;
      cond_reg    <= 3'b000;
      flags_reg   <= 3'b000;
      pending_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if (transfer) begin
        cls_reg  <= bus.instr_class;
        cond_reg <= bus.cond;
      end
      if (state_reg == START)
        cnt_reg <= '0;
      else if (state_reg == EXEC)
        cnt_reg <= cnt_reg + 1'b1;
      if (commit)
        flags_reg <= {bus.alu_n, bus.alu_v, bus.alu_z};
      // A late done on the final cycle still counts as success.
      if ((state_reg == EXEC) && !bus.alu_done && timeout_hit)
        err_reg <= 1'b1;
      if (commit)
        pending_reg <= 1'b1;
      else if ((state_reg == IDLE) || (state_reg == BR_WAIT))
        pending_reg <= 1'b0;
    end
  end

  assign bus.negative_flag_and = flags_reg[2];
  assign bus.overflow_and      = flags_reg[1];
  assign bus.zero_flag_and     = flags_reg[0];
  assign bus.alu_err           = err_reg;

endmodule
